// File: rtl/cell_pipe_pkg.sv
// rtl/cell_pipe_pkg.sv - shared cell-pipeline defaults, state encoding and helpers
package cell_pipe_pkg;

    localparam int DEF_CELL_WIDTH = 768;
    localparam int DEF_CELL_NUM   = 1200;
    localparam int DEF_BEAT_WIDTH = 256;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_START = 2'd3;

    // Counter width that never collapses to zero bits for a single-beat cell
    function automatic int min1_clog2(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cell_store_packer.sv
// rtl/cell_store_packer.sv - packs upstream beats into cells and registers the cell write
module cell_packer
    import cell_pipe_pkg::*;
#(
    parameter int CELL_WIDTH = DEF_CELL_WIDTH,
    parameter int BEAT_WIDTH = DEF_BEAT_WIDTH,
    parameter int ADDR_W     = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  beat_accept,
    input  logic [BEAT_WIDTH-1:0] beat_data,
    input  logic [ADDR_W-1:0]     cell_addr,
    output logic                  cell_done,
    output logic                  wr,
    output logic [ADDR_W-1:0]     addr,
    output logic [CELL_WIDTH-1:0] data
);

    localparam int BEATS_PER_CELL = CELL_WIDTH / BEAT_WIDTH;
    localparam int BEAT_CNT_W     = min1_clog2(BEATS_PER_CELL);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_CELL - 1);

    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [CELL_WIDTH-1:0] asm_q;
    logic [CELL_WIDTH-1:0] asm_next;

    assign cell_done = beat_accept && (beat_cnt == LAST_BEAT);

    // Current beat merged into its lane so the last beat can go straight to the write stage
    always_comb begin
        asm_next = asm_q;
        asm_next[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
    end

    // Beat counter and assembly register; clear only arrives while no beats flow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            asm_q    <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (beat_accept) begin
            asm_q    <= asm_next;
            beat_cnt <= cell_done ? '0 : beat_cnt + BEAT_CNT_W'(1);
        end
    end

    // Write stage kept apart from assembly so the next cell's beat 0 overlaps the write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr   <= 1'b0;
            addr <= '0;
            data <= '0;
        end else begin
            wr <= cell_done;
            if (cell_done) begin
                addr <= cell_addr;
                data <= asm_next;
            end
        end
    end

endmodule

// File: rtl/cell_store.sv
// rtl/cell_store.sv - captures one frame of beats into the Cell Cache and kicks the fetcher
module cell_store
    import cell_pipe_pkg::*;
#(
    parameter int CELL_WIDTH = DEF_CELL_WIDTH,
    parameter int CELL_NUM   = DEF_CELL_NUM,
    parameter int BEAT_WIDTH = DEF_BEAT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          frame_start_i,
    input  logic [BEAT_WIDTH-1:0]         bwd_beat_data_i,
    input  logic                          bwd_beat_valid_i,
    output logic                          bwd_beat_ready_o,
    output logic                          fwd_cell_wr_o,
    output logic [$clog2(CELL_NUM)-1:0]   fwd_cell_addr_o,
    output logic [CELL_WIDTH-1:0]         fwd_cell_data_o,
    output logic                          cell_fetch_start_o,
    output logic                          busy_o
);

    localparam int CELL_ADDR_W = $clog2(CELL_NUM);
    localparam logic [CELL_ADDR_W-1:0] LAST_CELL = CELL_ADDR_W'(CELL_NUM - 1);

    logic [1:0]             state;
    logic [CELL_ADDR_W-1:0] cell_cnt;
    logic                   beat_accept;
    logic                   cell_done;
    logic                   frame_go;

    assign bwd_beat_ready_o   = (state == ST_FILL);
    assign beat_accept        = bwd_beat_valid_i && bwd_beat_ready_o;
    assign frame_go           = frame_start_i && (state == ST_IDLE);
    assign cell_fetch_start_o = (state == ST_START);
    assign busy_o             = (state != ST_IDLE);

    cell_packer #(
        .CELL_WIDTH (CELL_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .ADDR_W     (CELL_ADDR_W)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (frame_go),
        .beat_accept (beat_accept),
        .beat_data   (bwd_beat_data_i),
        .cell_addr   (cell_cnt),
        .cell_done   (cell_done),
        .wr          (fwd_cell_wr_o),
        .addr        (fwd_cell_addr_o),
        .data        (fwd_cell_data_o)
    );

    // Frame sequencing and cell counter; the last cell's write lands during FLUSH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cell_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        state    <= ST_FILL;
                        cell_cnt <= '0;
                    end
                end
                ST_FILL: begin
                    if (cell_done) begin
                        cell_cnt <= cell_cnt + CELL_ADDR_W'(1);
                        if (cell_cnt == LAST_CELL) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: state <= ST_START;
                ST_START: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_store.sv
// tb/tb_cell_store.sv - self-checking bench for cell_store with a write/start scoreboard
module tb_cell_store;

    localparam int CW = 768;
    localparam int CN = 4;
    localparam int BW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          valid = 1'b0;
    logic [BW-1:0] bdata = '0;
    logic          ready;
    logic          wr;
    logic [1:0]    addr;
    logic [CW-1:0] data;
    logic          fetch_start;
    logic          busy;

    cell_store #(
        .CELL_WIDTH (CW),
        .CELL_NUM   (CN),
        .BEAT_WIDTH (BW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .frame_start_i      (frame_start),
        .bwd_beat_data_i    (bdata),
        .bwd_beat_valid_i   (valid),
        .bwd_beat_ready_o   (ready),
        .fwd_cell_wr_o      (wr),
        .fwd_cell_addr_o    (addr),
        .fwd_cell_data_o    (data),
        .cell_fetch_start_o (fetch_start),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int start_count = 0;

    typedef struct {
        logic [1:0]    addr;
        logic [CW-1:0] data;
        int            cyc;
    } wexp_t;

    wexp_t         wq[$];
    int            sq[$];
    wexp_t         mon_e;
    int            mon_s;
    logic [CW-1:0] m_asm = '0;
    int            m_bk = 0;
    int            m_ci = 0;

    typedef struct {
        bit         rnd;
        bit         restart;
        logic [7:0] base;
        int         exp_wr;
        int         exp_st;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: beat k of a cell fills lane k; a completed cell is due one cycle later
    task automatic model_accept(input logic [BW-1:0] d);
        m_asm[m_bk*BW +: BW] = d;
        m_bk++;
        if (m_bk == 3) begin
            wq.push_back('{addr: 2'(m_ci), data: m_asm, cyc: cyc + 1});
            m_asm = '0;
            m_bk  = 0;
            m_ci++;
            if (m_ci == CN) begin
                m_ci = 0;
                sq.push_back(cyc + 2);
            end
        end
    endtask

    // Scoreboard: every write and start pulse must match the head of its queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr) begin
                wr_count++;
                if (wq.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    mon_e = wq.pop_front();
                    chk("wr_addr", addr, mon_e.addr);
                    chk("wr_data", data, mon_e.data);
                    chk("wr_cycle", cyc, mon_e.cyc);
                end
            end
            if (fetch_start) begin
                start_count++;
                if (sq.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                end else begin
                    mon_s = sq.pop_front();
                    chk("start_cycle", cyc, mon_s);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_wr", wr, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_start", fetch_start, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wq.delete();
        sq.delete();
        m_asm = '0;
        m_bk  = 0;
        m_ci  = 0;
    endtask

    task automatic send_beats(input int n, input bit rnd, input bit restart, input logic [7:0] base);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < 400) begin
            valid       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            frame_start = restart && (guard == 6);
            bdata       = BW'(int'(base) + sent);
            @(negedge clk);
            chk("ready_in_fill", ready, 1);
            if (valid && ready) begin
                model_accept(bdata);
                sent++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        valid       = 1'b0;
        frame_start = 1'b0;
        if (sent < n) chk("beat_timeout", sent, n);
    endtask

    int w0;
    int s0;

    initial begin
        vecs[0] = '{rnd: 1'b0, restart: 1'b0, base: 8'h01, exp_wr: 4, exp_st: 1};
        vecs[1] = '{rnd: 1'b1, restart: 1'b0, base: 8'h01, exp_wr: 4, exp_st: 1};
        vecs[2] = '{rnd: 1'b0, restart: 1'b1, base: 8'h41, exp_wr: 4, exp_st: 1};
        vecs[3] = '{rnd: 1'b1, restart: 1'b1, base: 8'h81, exp_wr: 4, exp_st: 1};

        idle(1);
        do_reset();

        // No frame armed: valid alone must not start anything
        w0 = wr_count;
        s0 = start_count;
        valid = 1'b1;
        bdata = BW'(8'hAA);
        repeat (20) begin
            @(negedge clk);
            chk("idle_ready", ready, 0);
            chk("idle_busy", busy, 0);
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        chk("idle_writes", wr_count - w0, 0);
        chk("idle_starts", start_count - s0, 0);

        for (int i = 0; i < 4; i++) begin
            w0 = wr_count;
            s0 = start_count;
            pulse_fs();
            send_beats(12, vecs[i].rnd, vecs[i].restart, vecs[i].base);
            idle(6);
            chk("vec_writes", wr_count - w0, vecs[i].exp_wr);
            chk("vec_starts", start_count - s0, vecs[i].exp_st);
            chk("vec_wq_empty", wq.size(), 0);
            chk("vec_sq_empty", sq.size(), 0);
            chk("vec_busy_after", busy, 0);
        end

        // Reset after 5 beats abandons the frame; next frame starts at address 0
        pulse_fs();
        send_beats(5, 1'b0, 1'b0, 8'h11);
        idle(2);
        do_reset();
        idle(3);
        w0 = wr_count;
        s0 = start_count;
        chk("post_rst_no_write", wr_count - w0, 0);
        pulse_fs();
        send_beats(12, 1'b0, 1'b0, 8'h21);
        idle(6);
        chk("post_rst_writes", wr_count - w0, 4);
        chk("post_rst_starts", start_count - s0, 1);
        chk("post_rst_wq_empty", wq.size(), 0);

        // Second frame armed in the cycle right after START
        w0 = wr_count;
        s0 = start_count;
        pulse_fs();
        send_beats(12, 1'b0, 1'b0, 8'h31);
        idle(2);
        chk("b2b_idle_before", busy, 0);
        pulse_fs();
        chk("b2b_busy_again", busy, 1);
        send_beats(12, 1'b0, 1'b0, 8'h51);
        idle(6);
        chk("b2b_writes", wr_count - w0, 8);
        chk("b2b_starts", start_count - s0, 2);
        chk("b2b_wq_empty", wq.size(), 0);
        chk("b2b_sq_empty", sq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
